burst_mem_slave: RTL

//  Memory-side responder sitting directly downstream of the Top master FSM.
//  - Consumes the master's wr/rd/address/length/wdata request.
//  - Produces ready, rdata and rddatavalid back to the master.
//  - Backs requests with a DEPTH-word register-file memory; supports incrementing bursts.

---
 rtl/burst_mem_slave.sv | 133 +++++++++++++
 1 files changed

// File: rtl/burst_mem_slave.sv
// Burst-capable register-file memory responder for the Top master FSM.
// Handles incrementing write/read bursts with a configurable read latency.
module burst_mem_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [ADDR_W-1:0] io_address,
    input  logic [LEN_W-1:0]  io_length,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ready,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_rddatavalid
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        RD_BURST
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   remaining;
    logic [WAIT_W-1:0]  wait_cnt;

    logic [LEN_W-1:0]   beats;
    logic               accept;
    logic               wr_accept;
    logic               rd_accept;
    logic               burst_write;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;

    // A write and a read in the same request cycle resolve to the write.
    always_comb begin
        beats       = (io_length == '0) ? LEN_W'(1) : io_length;
        accept      = (state == IDLE) && io_ready && (io_wr || io_rd);
        wr_accept   = accept && io_wr;
        rd_accept   = accept && !io_wr;
        burst_write = (state == WRITE) && io_wr;
        mem_we      = !reset && (wr_accept || burst_write);
        mem_waddr   = wr_accept ? io_address : addr;
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= io_wdata;
        end
    end

    // addr always points at the next word to be written or read.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            io_ready       <= 1'b0;
            io_rddatavalid <= 1'b0;
            io_rdata       <= '0;
            addr           <= '0;
            remaining      <= '0;
            wait_cnt       <= '0;
        end else begin
            io_rddatavalid <= 1'b0;
            case (state)
                IDLE: begin
                    io_ready <= 1'b1;
                    if (wr_accept) begin
                        addr      <= io_address + 1'b1;
                        remaining <= beats - 1'b1;
                        if (beats != LEN_W'(1)) begin
                            state <= WRITE;
                        end
                    end else if (rd_accept) begin
                        io_ready <= 1'b0;
                        if (RD_LAT == 1) begin
                            io_rddatavalid <= 1'b1;
                            io_rdata       <= mem[io_address];
                            addr           <= io_address + 1'b1;
                            remaining      <= beats - 1'b1;
                            if (beats != LEN_W'(1)) begin
                                state <= RD_BURST;
                            end
                        end else begin
                            addr      <= io_address;
                            remaining <= beats;
                            wait_cnt  <= WAIT_W'(RD_LAT - 2);
                            state     <= (RD_LAT == 2) ? RD_BURST : RD_WAIT;
                        end
                    end
                end
                WRITE: begin
                    io_ready <= 1'b1;
                    if (io_wr) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == WAIT_W'(1)) begin
                        state <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    io_rddatavalid <= 1'b1;
                    io_rdata       <= mem[addr];
                    addr           <= addr + 1'b1;
                    remaining      <= remaining - 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
